// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding, MNT field layout and sizing constants for the MAC sequencer
package mac_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    CFG  = 4'd1,
    RDI  = 4'd2,
    RDW  = 4'd3,
    LW   = 4'd4,
    COMP = 4'd5,
    WR   = 4'd6,
    ZW   = 4'd7,
    FIN  = 4'd8
  } state_e;

  localparam int M_LSB   = 8;
  localparam int N_LSB   = 4;
  localparam int T_LSB   = 0;
  localparam int FIELD_W = 4;
  localparam int MAX_DIM = 8;
  localparam int LANES   = 4;

  function automatic logic dim_ok(input logic [FIELD_W-1:0] v);
    return (v != '0) && (int'(v) <= MAX_DIM);
  endfunction

endpackage

// File: rtl/mac_cfg_decode.sv
// rtl/mac_cfg_decode.sv - latches M/N/T on an accepted start and answers legality, entry and lane-mask queries
module mac_cfg_decode
  import mac_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [11:0]        mnt_i,
  input  logic [3:0]         ev_addr_i,
  input  logic               mask_h_i,
  output logic               legal_o,
  output logic               entry_valid_o,
  output logic [LANES-1:0]   lane_mask_o,
  output logic [FIELD_W-1:0] n_o
);

  logic [FIELD_W-1:0] m_q, n_q, t_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_q <= '0;
      n_q <= '0;
      t_q <= '0;
    end else if (load_i) begin
      m_q <= mnt_i[M_LSB +: FIELD_W];
      n_q <= mnt_i[N_LSB +: FIELD_W];
      t_q <= mnt_i[T_LSB +: FIELD_W];
    end
  end

  assign legal_o = dim_ok(m_q) && dim_ok(n_q) && dim_ok(t_q);

  // Entry (t,h) has work only if input row t exists and its first weight row 4h is in range.
  assign entry_valid_o = ({1'b0, ev_addr_i[3:1]} < t_q) &&
                         ({1'b0, ev_addr_i[0], 2'b00} < m_q);

  always_comb begin
    lane_mask_o = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_mask_o[k] = (LANES * int'(mask_h_i) + k) < int'(m_q);
    end
  end

  assign n_o = n_q;

endmodule

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - sequencing FSM driving the input/weight/output SRAMs and the int8 dot-product datapath
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int AW_I   = 3,
  parameter int AW_O   = 4,
  parameter int DP_LAT = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [11:0]     MNT,
  output logic            EN_I,
  output logic [AW_I-1:0] ADDR_I,
  output logic            EN_W,
  output logic [AW_I-1:0] ADDR_W,
  output logic            EN_O,
  output logic            RW_O,
  output logic [AW_O-1:0] ADDR_O,
  output logic            I_LOAD,
  output logic            W_LOAD,
  output logic [1:0]      W_SEL,
  output logic            DP_GO,
  output logic [3:0]      LANE_MASK,
  output logic [3:0]      N_CFG,
  output logic            ZERO_O,
  output logic            BUSY,
  output logic            DONE,
  output logic            ERR
);

  localparam logic [1:0] COMP_LAST = 2'(DP_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  addr_q, addr_d, addr_nxt;
  logic [1:0]  k_q, k_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        start_q;
  logic        start_acc;
  logic        legal, entry_valid;
  logic [LANES-1:0] lane_mask;

  logic            en_i_q, en_i_d, en_w_q, en_w_d, en_o_q, en_o_d;
  logic [AW_I-1:0] addr_i_q, addr_i_d, addr_w_q, addr_w_d;
  logic [AW_O-1:0] addr_o_q, addr_o_d;
  logic            i_load_q, i_load_d, w_load_q, w_load_d, dp_go_q, dp_go_d;
  logic [1:0]      w_sel_q, w_sel_d;
  logic [3:0]      lane_mask_q, lane_mask_d;
  logic            zero_q, zero_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

  assign start_acc = (state_q == IDLE) && START && !start_q;
  assign addr_nxt  = (state_q == CFG) ? 4'd0 : addr_q + 4'd1;

  mac_cfg_decode u_cfg (
    .clk_i         (CLK),
    .rst_i         (RST),
    .load_i        (start_acc),
    .mnt_i         (MNT),
    .ev_addr_i     (addr_nxt),
    .mask_h_i      (addr_q[0]),
    .legal_o       (legal),
    .entry_valid_o (entry_valid),
    .lane_mask_o   (lane_mask),
    .n_o           (N_CFG)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      start_q <= START;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (start_acc) state_d = CFG;
      CFG: begin
        addr_d  = 4'd0;
        state_d = !legal ? FIN : (entry_valid ? RDI : ZW);
      end
      RDI: begin
        state_d = RDW;
        k_d     = 2'd0;
      end
      RDW: begin
        if (k_q == 2'd3) state_d = LW;
        else             k_d     = k_q + 2'd1;
      end
      LW: begin
        state_d = COMP;
        cnt_d   = 2'd0;
      end
      COMP: begin
        if (cnt_q == COMP_LAST) state_d = WR;
        else                    cnt_d   = cnt_q + 2'd1;
      end
      WR, ZW: begin
        if (addr_q == 4'd15) begin
          state_d = FIN;
        end else begin
          addr_d  = addr_nxt;
          state_d = entry_valid ? RDI : ZW;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every strobe leaves a flop in the cycle of its state.
  always_comb begin
    en_i_d      = (state_d == RDI);
    addr_i_d    = en_i_d ? AW_I'(addr_d[3:1]) : addr_i_q;
    en_w_d      = (state_d == RDW);
    addr_w_d    = en_w_d ? AW_I'({addr_d[0], k_d}) : addr_w_q;
    en_o_d      = (state_d == WR) || (state_d == ZW);
    addr_o_d    = en_o_d ? AW_O'(addr_d) : addr_o_q;
    i_load_d    = (state_d == RDW) && (k_d == 2'd0);
    w_load_d    = ((state_d == RDW) && (k_d != 2'd0)) || (state_d == LW);
    w_sel_d     = w_sel_q;
    if (state_d == LW)                        w_sel_d = 2'd3;
    else if (state_d == RDW && k_d != 2'd0)   w_sel_d = k_d - 2'd1;
    dp_go_d     = (state_d == COMP) && (cnt_d == 2'd0);
    lane_mask_d = (state_d == WR) ? lane_mask : 4'd0;
    zero_d      = (state_d == ZW);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == FIN);
    err_d       = err_q;
    if (state_d == CFG)                err_d = 1'b0;
    else if (state_d == FIN && !legal) err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      en_i_q <= 1'b0; addr_i_q <= '0; en_w_q <= 1'b0; addr_w_q <= '0;
      en_o_q <= 1'b0; addr_o_q <= '0; i_load_q <= 1'b0; w_load_q <= 1'b0;
      w_sel_q <= '0; dp_go_q <= 1'b0; lane_mask_q <= '0; zero_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0;
    end else begin
      en_i_q <= en_i_d; addr_i_q <= addr_i_d; en_w_q <= en_w_d; addr_w_q <= addr_w_d;
      en_o_q <= en_o_d; addr_o_q <= addr_o_d; i_load_q <= i_load_d; w_load_q <= w_load_d;
      w_sel_q <= w_sel_d; dp_go_q <= dp_go_d; lane_mask_q <= lane_mask_d; zero_q <= zero_d;
      busy_q <= busy_d; done_q <= done_d; err_q <= err_d;
    end
  end

  assign EN_I      = en_i_q;
  assign ADDR_I    = addr_i_q;
  assign EN_W      = en_w_q;
  assign ADDR_W    = addr_w_q;
  assign EN_O      = en_o_q;
  assign RW_O      = en_o_q;
  assign ADDR_O    = addr_o_q;
  assign I_LOAD    = i_load_q;
  assign W_LOAD    = w_load_q;
  assign W_SEL     = w_sel_q;
  assign DP_GO     = dp_go_q;
  assign LANE_MASK = lane_mask_q;
  assign ZERO_O    = zero_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - scoreboard bench for mac_seq_ctrl with a run-level reference model
module tb_mac_seq_ctrl;

  localparam int DP_LAT = 2;

  localparam int K_RDI = 0, K_RDW = 1, K_ILD = 2, K_WLD = 3, K_GO = 4, K_WR = 5, K_DONE = 6;

  typedef struct {
    int kind;
    int cyc;
    int a;
    int b;
  } ev_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [11:0] MNT = 12'h000;
  logic        EN_I, EN_W, EN_O, RW_O, I_LOAD, W_LOAD, DP_GO, ZERO_O, BUSY, DONE, ERR;
  logic [2:0]  ADDR_I, ADDR_W;
  logic [3:0]  ADDR_O, LANE_MASK, N_CFG;
  logic [1:0]  W_SEL;

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  base  = 0;
  ev_t exp_q[$];

  mac_seq_ctrl #(.AW_I(3), .AW_O(4), .DP_LAT(DP_LAT)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MNT(MNT),
    .EN_I(EN_I), .ADDR_I(ADDR_I), .EN_W(EN_W), .ADDR_W(ADDR_W),
    .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O),
    .I_LOAD(I_LOAD), .W_LOAD(W_LOAD), .W_SEL(W_SEL), .DP_GO(DP_GO),
    .LANE_MASK(LANE_MASK), .N_CFG(N_CFG), .ZERO_O(ZERO_O),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  function automatic string kname(input int kind);
    case (kind)
      K_RDI:   return "en_i";
      K_RDW:   return "en_w";
      K_ILD:   return "i_load";
      K_WLD:   return "w_load";
      K_GO:    return "dp_go";
      K_WR:    return "write";
      default: return "done";
    endcase
  endfunction

  function automatic void push(input int kind, input int c, input int a, input int b);
    ev_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.b = b;
    exp_q.push_back(e);
  endfunction

  // Reference: walk the 16 output entries with per-entry costs taken straight from the run rules.
  function automatic void model_run(input logic [11:0] mnt, input int b0);
    int m, n, t, c, tt, hh, mask;
    m = int'(mnt[11:8]); n = int'(mnt[7:4]); t = int'(mnt[3:0]);
    if (m < 1 || m > 8 || n < 1 || n > 8 || t < 1 || t > 8) begin
      push(K_DONE, b0 + 2, 1, 1);
      return;
    end
    c = b0 + 2;
    for (int a = 0; a < 16; a++) begin
      tt = a / 2; hh = a % 2;
      if (tt < t && 4 * hh < m) begin
        push(K_RDI, c, tt, 0);
        for (int k = 0; k < 4; k++) begin
          push(K_RDW, c + 1 + k, 4 * hh + k, 0);
          if (k == 0) push(K_ILD, c + 1, 0, 0);
          else        push(K_WLD, c + 1 + k, k - 1, 0);
        end
        push(K_WLD, c + 5, 3, 0);
        push(K_GO, c + 6, 0, 0);
        mask = 0;
        for (int k = 0; k < 4; k++) if (4 * hh + k < m) mask = mask | (1 << k);
        push(K_WR, c + 6 + DP_LAT, a, (mask << 4) | n);
        c = c + 7 + DP_LAT;
      end else begin
        push(K_WR, c, a, (1 << 8) | n);
        c = c + 1;
      end
    end
    push(K_DONE, c, 0, 1);
  endfunction

  task automatic observe(input int kind, input int a, input int b);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s cyc=%0d got a=%0d b=%0d, required no event", kname(kind), cyc, a, b);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.a != a || e.b != b) begin
        bad++;
        $display("FAIL event got %s@%0d a=%0d b=%0d, required %s@%0d a=%0d b=%0d",
                 kname(kind), cyc, a, b, kname(e.kind), e.cyc, e.a, e.b);
      end
    end
  endtask

  always @(negedge CLK) begin
    if (EN_I || EN_W || EN_O) begin
      total++;
      if ((EN_I && EN_W) || (RW_O != EN_O)) begin
        bad++;
        $display("FAIL enables cyc=%0d got en_i=%0b en_w=%0b en_o=%0b rw_o=%0b, required exclusive reads and rw_o=en_o",
                 cyc, EN_I, EN_W, EN_O, RW_O);
      end
    end
    if (EN_I)   observe(K_RDI, int'(ADDR_I), 0);
    if (EN_W)   observe(K_RDW, int'(ADDR_W), 0);
    if (I_LOAD) observe(K_ILD, 0, 0);
    if (W_LOAD) observe(K_WLD, int'(W_SEL), 0);
    if (DP_GO)  observe(K_GO, 0, 0);
    if (EN_O)   observe(K_WR, int'(ADDR_O), (int'(ZERO_O) << 8) | (int'(LANE_MASK) << 4) | int'(N_CFG));
    if (DONE)   observe(K_DONE, int'(ERR), int'(BUSY));
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  function automatic int outs();
    return int'({EN_I, ADDR_I, EN_W, ADDR_W, EN_O, RW_O, ADDR_O, I_LOAD, W_LOAD, W_SEL,
                 DP_GO, LANE_MASK, N_CFG, ZERO_O, BUSY, DONE, ERR});
  endfunction

  task automatic start_run(input logic [11:0] mnt, input bit hold);
    @(negedge CLK);
    MNT = mnt;
    START = 1'b1;
    base = cyc;
    model_run(mnt, cyc);
    @(negedge CLK);
    if (!hold) START = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit && exp_q.size() != 0; i++) @(negedge CLK);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL run_timeout got %0d events pending, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge CLK);
  endtask

  function automatic logic [11:0] rnd_mnt();
    logic [11:0] v;
    int r;
    for (int f = 0; f < 3; f++) begin
      r = $urandom_range(0, 19);
      v[f*4 +: 4] = (r == 0) ? 4'd0 : (r == 1) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(1, 8));
    end
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t keep[$];
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("reset_outputs", outs(), 0);

    start_run(12'h444, 0); wait_idle(200);
    start_run(12'h888, 0); wait_idle(300);
    start_run(12'h183, 0); wait_idle(200);

    start_run(12'h045, 0); wait_idle(20);
    repeat (3) @(negedge CLK);
    check("err_held", int'(ERR), 1);
    check("idle_after_err", int'(BUSY), 0);
    start_run(12'h444, 0);
    check("err_cleared_cfg", int'(ERR), 0);
    check("busy_in_cfg", int'(BUSY), 1);
    wait_idle(200);

    // START held high and toggled while busy must not launch a second run.
    start_run(12'h222, 1);
    repeat (5) @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    wait_idle(200);
    repeat (30) @(negedge CLK);
    check("no_rerun_busy", int'(BUSY), 0);
    START = 1'b0;
    @(negedge CLK);
    start_run(12'h222, 0); wait_idle(200);

    // Reset in the first COMP cycle of entry 2.
    start_run(12'h444, 0);
    while (cyc < base + 18) @(negedge CLK);
    RST = 1'b1;
    keep.delete();
    foreach (exp_q[i]) if (exp_q[i].cyc <= base + 18) keep.push_back(exp_q[i]);
    exp_q = keep;
    @(negedge CLK);
    check("mid_reset_outputs", outs(), 0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("mid_reset_pending", exp_q.size(), 0);
    check("mid_reset_idle", int'(BUSY), 0);
    start_run(12'h444, 0); wait_idle(200);

    for (int r = 0; r < 8; r++) begin
      start_run(rnd_mnt(), 0);
      wait_idle(300);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
